// File: rtl/ultra_sonic_echo_emulator.sv
// HC-SR04-style responder: qualifies a trigger pulse, waits a burst delay, then drives a programmed-width echo.
// Optional echo-width jitter from a 16-bit LFSR is enabled by defining ULTRA_SONIC_ECHO_JITTER_EN.
module ultra_sonic_echo_emulator #(
    parameter int COUNT_WIDTH     = 22,
    parameter int MIN_TRIG_CYCLES = 500,
    parameter int BURST_CYCLES    = 10000,
    parameter int MAX_ECHO_CYCLES = 1250000,
    parameter int TIMEOUT_CYCLES  = 1900000,
    parameter int HOLDOFF_CYCLES  = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic [31:0] write_data,
    input  logic        write_valid,
    output logic        echo,
    output logic        busy,
    output logic [7:0]  short_trig_count
);

    localparam logic [COUNT_WIDTH-1:0] MIN_T   = COUNT_WIDTH'(MIN_TRIG_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] BURST_T = COUNT_WIDTH'(BURST_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] MAX_T   = COUNT_WIDTH'(MAX_ECHO_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] TMO_T   = COUNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] HOLD_T  = COUNT_WIDTH'(HOLDOFF_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);

    // Bit 3 is busy and bit 2 is echo, so both outputs come straight off state flops.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0000,
        S_TRIG  = 4'b0001,
        S_BURST = 4'b1000,
        S_ECHO  = 4'b1100,
        S_HOLD  = 4'b1001
    } state_t;

    state_t                 state_q;
    logic                   sync1_q, trig_s_q, trig_sd_q;
    logic [COUNT_WIDTH-1:0] width_q, trig_cnt_q, cnt_q, eff_q;
    logic [COUNT_WIDTH-1:0] eff_d;
    logic [COUNT_WIDTH:0]   sum_d;
    logic [7:0]             short_q;
    logic                   unused_wdata;

    assign unused_wdata     = ^write_data[31:COUNT_WIDTH];
    assign busy             = state_q[3];
    assign echo             = state_q[2];
    assign short_trig_count = short_q;

`ifdef ULTRA_SONIC_ECHO_JITTER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lfsr_q <= 16'hACE1;
        else if (state_q == S_TRIG && !trig_s_q && trig_cnt_q >= MIN_T)
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    assign sum_d = {1'b0, width_q} + (COUNT_WIDTH+1)'(lfsr_q[3:0]);
`else
    assign sum_d = {1'b0, width_q};
`endif

    // Timeout width is exempt from jitter; everything else clamps after the add.
    always_comb begin
        eff_d = sum_d[COUNT_WIDTH-1:0];
        if (width_q == '0)
            eff_d = TMO_T;
        else if (sum_d > {1'b0, MAX_T})
            eff_d = MAX_T;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b0;
            trig_s_q   <= 1'b0;
            trig_sd_q  <= 1'b0;
            width_q    <= '0;
            trig_cnt_q <= '0;
            cnt_q      <= '0;
            eff_q      <= '0;
            short_q    <= '0;
        end else begin
            sync1_q   <= trigger;
            trig_s_q  <= sync1_q;
            trig_sd_q <= trig_s_q;
            if (write_valid)
                width_q <= write_data[COUNT_WIDTH-1:0];

            case (state_q)
                S_IDLE: begin
                    if (trig_s_q && !trig_sd_q) begin
                        state_q    <= S_TRIG;
                        trig_cnt_q <= ONE;
                    end
                end
                S_TRIG: begin
                    if (trig_s_q) begin
                        if (trig_cnt_q < MIN_T)
                            trig_cnt_q <= trig_cnt_q + ONE;
                    end else if (trig_cnt_q >= MIN_T) begin
                        state_q <= S_BURST;
                        cnt_q   <= BURST_T;
                        eff_q   <= eff_d;
                    end else begin
                        state_q <= S_IDLE;
                        if (short_q != 8'hFF)
                            short_q <= short_q + 8'd1;
                    end
                end
                S_BURST: begin
                    if (cnt_q == ONE) begin
                        state_q <= S_ECHO;
                        cnt_q   <= eff_q;
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                S_ECHO: begin
                    if (cnt_q == ONE) begin
                        state_q <= S_HOLD;
                        cnt_q   <= HOLD_T;
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == ONE)
                        state_q <= S_IDLE;
                    else
                        cnt_q <= cnt_q - ONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ultra_sonic_echo_emulator.sv
// Directed + randomized bench for ultra_sonic_echo_emulator with a protocol-level reference model.
// Define ULTRA_SONIC_ECHO_JITTER_EN for both files to exercise the jitter build.
module tb_ultra_sonic_echo_emulator;
    localparam int MIN_T = 4, BURST_T = 8, MAX_T = 40, TMO_T = 64, HOLD_T = 16;
    localparam int BUDGET = 300;

    logic        clk = 1'b0, reset = 1'b1, trigger = 1'b0, write_valid = 1'b0;
    logic [31:0] write_data = '0;
    logic        echo, busy;
    logic [7:0]  short_trig_count;

    int n_pass = 0, n_chk = 0, n_fail = 0;
    int m_cnt = 0, m_width = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    ultra_sonic_echo_emulator #(
        .COUNT_WIDTH(22), .MIN_TRIG_CYCLES(MIN_T), .BURST_CYCLES(BURST_T),
        .MAX_ECHO_CYCLES(MAX_T), .TIMEOUT_CYCLES(TMO_T), .HOLDOFF_CYCLES(HOLD_T)
    ) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .write_data(write_data),
        .write_valid(write_valid), .echo(echo), .busy(busy), .short_trig_count(short_trig_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected echo width for the next accepted trigger, from the current model state.
    function automatic int exp_width();
        int w;
        if (m_width == 0) return TMO_T;
        w = m_width;
`ifdef ULTRA_SONIC_ECHO_JITTER_EN
        w = w + int'(m_lfsr[3:0]);
`endif
        return (w > MAX_T) ? MAX_T : w;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic wr(input int v);
        @(negedge clk);
        write_data  = v;
        write_valid = 1'b1;
        @(negedge clk);
        write_valid = 1'b0;
        m_width = v & 32'h3F_FFFF;
    endtask

    task automatic pulse(input int n);
        @(negedge clk);
        trigger = 1'b1;
        repeat (n) @(negedge clk);
        trigger = 1'b0;
    endtask

    // Called right after trigger drops: d = edges from first low sample to echo rise,
    // w = echo high cycles, h = busy cycles after echo falls, bz = busy held during echo.
    task automatic measure(output int d, output int w, output int h, output int bz);
        d = 0; w = 0; h = 0; bz = 1;
        @(posedge clk);
        @(negedge clk);
        while (!echo && d < BUDGET) begin
            @(posedge clk); d++; @(negedge clk);
            if (!echo && !busy && d > 3) bz = 0;
        end
        while (echo && w < BUDGET) begin
            if (!busy) bz = 0;
            @(posedge clk); w++; @(negedge clk);
        end
        while (busy && h < BUDGET) begin
            @(posedge clk); h++; @(negedge clk);
        end
    endtask

    task automatic do_valid(input int n, input string tag, output int w);
        int d, h, bz, e;
        e = exp_width();
        pulse(n);
        measure(d, w, h, bz);
        m_lfsr = lfsr_next(m_lfsr);
        check({tag, "_delay"}, d, BURST_T + 2);
        check({tag, "_width"}, w, e);
        check({tag, "_holdoff"}, h, HOLD_T);
        check({tag, "_busy"}, bz, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_short(input int n, input string tag);
        int seen;
        seen = 0;
        pulse(n);
        repeat (12) begin
            @(negedge clk);
            if (echo || busy) seen = 1;
        end
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        check({tag, "_noecho"}, seen, 0);
        check({tag, "_count"}, short_trig_count, m_cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        m_cnt = 0; m_width = 0; m_lfsr = 16'hACE1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int w, d, h, bz, c, e;
        int jw[3];

        #12;
        check("rst_echo", echo, 0);
        check("rst_busy", busy, 0);
        check("rst_count", short_trig_count, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Basic pulse, short trigger rejection and counter saturation
        wr(20);
        do_valid(6, "t1", w);
        do_short(3, "t2");
        repeat (260) begin
            pulse(3);
            repeat (4) @(negedge clk);
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        repeat (4) @(negedge clk);
        check("t2_sat", short_trig_count, 255);

        // Timeout width and clamp, plus exactly-minimum trigger
        wr(0);
        do_valid(MIN_T, "t3_tmo", w);
        wr(100);
        do_valid(6, "t3_clamp", w);

        // Write during BURST and retriggers during ECHO/HOLDOFF
        wr(20);
        e = exp_width();
        pulse(6);
        fork
            measure(d, w, h, bz);
            begin
                repeat (3) @(negedge clk);
                write_data = 30; write_valid = 1'b1;
                @(negedge clk);
                write_valid = 1'b0;
                repeat (12) @(negedge clk);
                trigger = 1'b1;
                repeat (6) @(negedge clk);
                trigger = 1'b0;
                repeat (8) @(negedge clk);
                trigger = 1'b1;
                repeat (6) @(negedge clk);
                trigger = 1'b0;
            end
        join
        m_width = 30;
        m_lfsr = lfsr_next(m_lfsr);
        check("t4_delay", d, BURST_T + 2);
        check("t4_width", w, e);
        check("t4_holdoff", h, HOLD_T);
        repeat (6) @(negedge clk);
        check("t4_count", short_trig_count, m_cnt);
        check("t4_busy", busy, 0);
        do_valid(6, "t4_new", w);

        // Randomized trials against the model
        for (int i = 0; i < 10; i++) begin
            int wv, n;
            wv = $urandom_range(0, 120);
            if ($urandom_range(0, 3) == 0) wv = 0;
            n = $urandom_range(2, 8);
            wr(wv);
            if (n >= MIN_T) do_valid(n, "rnd", w);
            else do_short(n, "rnd_short");
        end

        // Asynchronous reset mid-ECHO
        wr(50);
        pulse(6);
        c = 0;
        while (!echo && c < BUDGET) begin @(negedge clk); c++; end
        check("t5_in_echo", echo, 1);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("t5_echo_async", echo, 0);
        check("t5_busy_async", busy, 0);
        check("t5_count_async", short_trig_count, 0);
        m_cnt = 0; m_width = 0; m_lfsr = 16'hACE1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        do_valid(6, "t5_after", w);

`ifdef ULTRA_SONIC_ECHO_JITTER_EN
        do_reset();
        wr(20);
        for (int i = 0; i < 3; i++) begin
            do_valid(6, "t6_jit", jw[i]);
            check("t6_le35", int'(jw[i] <= 35), 1);
        end
        do_reset();
        wr(20);
        for (int i = 0; i < 3; i++) begin
            do_valid(6, "t6_rep", w);
            check("t6_repeat", w, jw[i]);
        end
`else
        jw[0] = 0;
        do_reset();
        wr(20);
        do_valid(6, "t6_nojit", w);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
